// File: rtl/riscv_alu_arbiter_if.sv
// Request/response handshake bundle between two ALU requesters and the shared-ALU arbiter.
// Member names are the arbiter's own port names, so the slave view reads as its port list.
`ifndef XLEN
`define XLEN 32
`endif

interface riscv_alu_arbiter_if #(
  parameter int XLEN = `XLEN
);
  logic            i_req0_valid;
  logic            i_req1_valid;
  logic            o_req0_ready;
  logic            o_req1_ready;
  logic [XLEN-1:0] i_req0_a;
  logic [XLEN-1:0] i_req1_a;
  logic [XLEN-1:0] i_req0_b;
  logic [XLEN-1:0] i_req1_b;
  logic [3:0]      i_req0_ctrl;
  logic [3:0]      i_req1_ctrl;
  logic            i_req0_zcond;
  logic            i_req1_zcond;
  logic            o_rsp0_valid;
  logic            o_rsp1_valid;
  logic            i_rsp0_ready;
  logic            i_rsp1_ready;
  logic [XLEN-1:0] o_rsp0_result;
  logic [XLEN-1:0] o_rsp1_result;
  logic            o_rsp0_zero;
  logic            o_rsp1_zero;

  modport slave (
    input  i_req0_valid, i_req1_valid,
    input  i_req0_a, i_req1_a, i_req0_b, i_req1_b,
    input  i_req0_ctrl, i_req1_ctrl, i_req0_zcond, i_req1_zcond,
    input  i_rsp0_ready, i_rsp1_ready,
    output o_req0_ready, o_req1_ready,
    output o_rsp0_valid, o_rsp1_valid,
    output o_rsp0_result, o_rsp1_result, o_rsp0_zero, o_rsp1_zero
  );

  modport master (
    output i_req0_valid, i_req1_valid,
    output i_req0_a, i_req1_a, i_req0_b, i_req1_b,
    output i_req0_ctrl, i_req1_ctrl, i_req0_zcond, i_req1_zcond,
    output i_rsp0_ready, i_rsp1_ready,
    input  o_req0_ready, o_req1_ready,
    input  o_rsp0_valid, o_rsp1_valid,
    input  o_rsp0_result, o_rsp1_result, o_rsp0_zero, o_rsp1_zero
  );
endinterface

// File: rtl/riscv_alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational riscv_alu.
// One operation in flight: IDLE grants, EXEC samples the ALU, RESP holds the answer until taken.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_alu_arbiter #(
  parameter int XLEN = `XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  riscv_alu_arbiter_if.slave bus,
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  output logic [3:0]      o_alu_ctrl,
  output logic            o_alu_zcond,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic            i_alu_zero,
  output logic            o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_grant_q, last_grant_d;
  logic [XLEN-1:0] op_a_q, op_a_d;
  logic [XLEN-1:0] op_b_q, op_b_d;
  logic [3:0]      op_ctrl_q, op_ctrl_d;
  logic            op_zcond_q, op_zcond_d;
  logic [XLEN-1:0] rsp0_result_q, rsp0_result_d;
  logic [XLEN-1:0] rsp1_result_q, rsp1_result_d;
  logic            rsp0_zero_q, rsp0_zero_d;
  logic            rsp1_zero_q, rsp1_zero_d;
  logic            rsp0_valid_q, rsp0_valid_d;
  logic            rsp1_valid_q, rsp1_valid_d;
  logic            req0_ready_c, req1_ready_c;
  logic            pick;
  logic            rsp_taken;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_ctrl_d     = op_ctrl_q;
    op_zcond_d    = op_zcond_q;
    rsp0_result_d = rsp0_result_q;
    rsp1_result_d = rsp1_result_q;
    rsp0_zero_d   = rsp0_zero_q;
    rsp1_zero_d   = rsp1_zero_q;
    rsp0_valid_d  = rsp0_valid_q;
    rsp1_valid_d  = rsp1_valid_q;
    req0_ready_c  = 1'b0;
    req1_ready_c  = 1'b0;
    pick          = 1'b0;
    rsp_taken     = grant_q ? bus.i_rsp1_ready : bus.i_rsp0_ready;

    case (state_q)
      S_IDLE: begin
        if (bus.i_req0_valid || bus.i_req1_valid) begin
          // On contention the requester that did not win last time goes first.
          pick = (bus.i_req0_valid && bus.i_req1_valid) ? ~last_grant_q
                                                        : bus.i_req1_valid;
          req0_ready_c = ~pick;
          req1_ready_c = pick;
          grant_d      = pick;
          op_a_d       = pick ? bus.i_req1_a     : bus.i_req0_a;
          op_b_d       = pick ? bus.i_req1_b     : bus.i_req0_b;
          op_ctrl_d    = pick ? bus.i_req1_ctrl  : bus.i_req0_ctrl;
          op_zcond_d   = pick ? bus.i_req1_zcond : bus.i_req0_zcond;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        if (grant_q) begin
          rsp1_result_d = i_alu_result;
          rsp1_zero_d   = i_alu_zero;
          rsp1_valid_d  = 1'b1;
        end else begin
          rsp0_result_d = i_alu_result;
          rsp0_zero_d   = i_alu_zero;
          rsp0_valid_d  = 1'b1;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_taken) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // last_grant resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_ctrl_q     <= '0;
      op_zcond_q    <= 1'b0;
      rsp0_result_q <= '0;
      rsp1_result_q <= '0;
      rsp0_zero_q   <= 1'b0;
      rsp1_zero_q   <= 1'b0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_ctrl_q     <= op_ctrl_d;
      op_zcond_q    <= op_zcond_d;
      rsp0_result_q <= rsp0_result_d;
      rsp1_result_q <= rsp1_result_d;
      rsp0_zero_q   <= rsp0_zero_d;
      rsp1_zero_q   <= rsp1_zero_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
    end
  end

  // Ready is combinational from IDLE, so it is gated by reset to read 0 while reset is held.
  assign bus.o_req0_ready  = req0_ready_c & ~i_rst;
  assign bus.o_req1_ready  = req1_ready_c & ~i_rst;
  assign bus.o_rsp0_valid  = rsp0_valid_q;
  assign bus.o_rsp1_valid  = rsp1_valid_q;
  assign bus.o_rsp0_result = rsp0_result_q;
  assign bus.o_rsp1_result = rsp1_result_q;
  assign bus.o_rsp0_zero   = rsp0_zero_q;
  assign bus.o_rsp1_zero   = rsp1_zero_q;

  assign o_alu_a     = op_a_q;
  assign o_alu_b     = op_b_q;
  assign o_alu_ctrl  = op_ctrl_q;
  assign o_alu_zcond = op_zcond_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_riscv_alu_arbiter.sv
// Bench for riscv_alu_arbiter: behavioural shared ALU, vector table, in-order scoreboard,
// plus hand sequences for backpressure and reset during EXEC.
module tb_riscv_alu_arbiter;
  localparam int XLEN = 32;
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_SLT   = 4'h2;
  localparam logic [3:0] OP_SLTU  = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_AND   = 4'h7;
  localparam logic [3:0] OP_UNDEF = 4'hF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  riscv_alu_arbiter_if #(.XLEN(XLEN)) bus ();

  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic [3:0]      alu_ctrl;
  logic            alu_zcond, alu_zero, busy;

  riscv_alu_arbiter #(.XLEN(XLEN)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .bus          (bus),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_ctrl   (alu_ctrl),
    .o_alu_zcond  (alu_zcond),
    .i_alu_result (alu_result),
    .i_alu_zero   (alu_zero),
    .o_busy       (busy)
  );

  // Behavioural stand-in for the shared ALU; undefined opcodes produce a marker value.
  always_comb begin
    alu_result = 32'hDEAD_BEEF;
    case (alu_ctrl)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_SLT:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      OP_SLTU: alu_result = {31'd0, alu_a < alu_b};
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_AND:  alu_result = alu_a & alu_b;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end
  assign alu_zero = alu_zcond ? (alu_result != '0) : (alu_result == '0);

  typedef struct {
    int              req;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      ctrl;
    logic            zcond;
    logic [XLEN-1:0] res;
    logic            zero;
  } vec_t;

  typedef struct {
    int              req;
    logic [XLEN-1:0] res;
    logic            zero;
    int              cyc;
  } exp_t;

  vec_t vt [12];
  exp_t sb [$];
  int   q0 [$];
  int   q1 [$];
  int   order [$];
  int   exp_order [$];
  logic [XLEN-1:0] last_res [2];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive_req(input int r, input int vi);
    if (r == 0) begin
      bus.i_req0_valid = 1'b1; bus.i_req0_a = vt[vi].a; bus.i_req0_b = vt[vi].b;
      bus.i_req0_ctrl = vt[vi].ctrl; bus.i_req0_zcond = vt[vi].zcond;
    end else begin
      bus.i_req1_valid = 1'b1; bus.i_req1_a = vt[vi].a; bus.i_req1_b = vt[vi].b;
      bus.i_req1_ctrl = vt[vi].ctrl; bus.i_req1_zcond = vt[vi].zcond;
    end
  endtask

  task automatic idle_req(input int r);
    if (r == 0) bus.i_req0_valid = 1'b0;
    else        bus.i_req1_valid = 1'b0;
  endtask

  task automatic take_rsp(input int r);
    exp_t e;
    logic [XLEN-1:0] res;
    logic z;
    res = (r == 0) ? bus.o_rsp0_result : bus.o_rsp1_result;
    z   = (r == 0) ? bus.o_rsp0_zero   : bus.o_rsp1_zero;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_rsp requester=%0d actual=valid required=none", r);
    end else begin
      e = sb.pop_front();
      $display("rsp r%0d result=%08h zero=%0b latency=%0d", r, res, z, cyc - e.cyc);
      check("rsp_requester", r, e.req);
      check("rsp_result", res, e.res);
      check("rsp_zero", z, e.zero);
      check("rsp_latency", cyc - e.cyc, 2);
      check("other_rsp_held", (r == 0) ? bus.o_rsp1_result : bus.o_rsp0_result, last_res[1-r]);
      last_res[r] = e.res;
    end
  endtask

  // Feeds q0/q1 with always-ready responses until both queues and the scoreboard drain.
  task automatic run_ops(input int budget);
    int  n;
    bit  acc0, acc1;
    n = 0;
    order.delete();
    bus.i_rsp0_ready = 1'b1;
    bus.i_rsp1_ready = 1'b1;
    if (q0.size() > 0) drive_req(0, q0[0]); else idle_req(0);
    if (q1.size() > 0) drive_req(1, q1[0]); else idle_req(1);
    while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && n < budget) begin
      @(negedge clk);
      acc0 = 1'b0; acc1 = 1'b0;
      check("one_rsp_valid", bus.o_rsp0_valid & bus.o_rsp1_valid, 0);
      check("ready_low_busy", busy & (bus.o_req0_ready | bus.o_req1_ready), 0);
      check("ready_exclusive", bus.o_req0_ready & bus.o_req1_ready, 0);
      if (bus.o_rsp0_valid) take_rsp(0);
      if (bus.o_rsp1_valid) take_rsp(1);
      if (bus.o_req0_ready && bus.i_req0_valid) begin
        sb.push_back('{0, vt[q0[0]].res, vt[q0[0]].zero, cyc});
        order.push_back(0); void'(q0.pop_front()); acc0 = 1'b1;
      end
      if (bus.o_req1_ready && bus.i_req1_valid) begin
        sb.push_back('{1, vt[q1[0]].res, vt[q1[0]].zero, cyc});
        order.push_back(1); void'(q1.pop_front()); acc1 = 1'b1;
      end
      @(posedge clk); #1;
      if (acc0) begin if (q0.size() > 0) drive_req(0, q0[0]); else idle_req(0); end
      if (acc1) begin if (q1.size() > 0) drive_req(1, q1[0]); else idle_req(1); end
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL run_timeout actual=%0d cycles required=<%0d", n, budget);
      q0.delete(); q1.delete(); sb.delete();
    end
    idle_req(0); idle_req(1);
    check("order_len", order.size(), exp_order.size());
    for (int k = 0; k < exp_order.size() && k < order.size(); k++)
      check("grant_order", order[k], exp_order[k]);
  endtask

  task automatic wait_ready(input int r, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((r == 0 && bus.o_req0_ready) || (r == 1 && bus.o_req1_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_ready_timeout requester=%0d actual=no grant required=grant", r);
    end
  endtask

  initial begin
    bit ok;
    vt[0]  = '{0, 32'd5,          32'd7,          OP_ADD,   1'b0, 32'd12,         1'b0};
    vt[1]  = '{0, 32'd9,          32'd9,          OP_SUB,   1'b0, 32'd0,          1'b1};
    vt[2]  = '{1, 32'h0000_000F,  32'h0000_00F0,  OP_XOR,   1'b0, 32'h0000_00FF,  1'b0};
    vt[3]  = '{0, 32'hFFFF_FFFF,  32'd0,          OP_SLT,   1'b1, 32'd1,          1'b1};
    vt[4]  = '{1, 32'd1,          32'hFFFF_FFFF,  OP_SLTU,  1'b0, 32'd1,          1'b0};
    vt[5]  = '{0, 32'h1234_5678,  32'h9ABC_DEF0,  OP_UNDEF, 1'b0, 32'hDEAD_BEEF,  1'b0};
    vt[6]  = '{1, 32'h0000_F0F0,  32'h0000_FF00,  OP_AND,   1'b0, 32'h0000_F000,  1'b0};
    vt[7]  = '{0, 32'd0,          32'd0,          OP_OR,    1'b0, 32'd0,          1'b1};
    vt[8]  = '{1, 32'hFFFF_FFFF,  32'd1,          OP_ADD,   1'b0, 32'd0,          1'b1};
    vt[9]  = '{1, 32'd0,          32'd1,          OP_SUB,   1'b1, 32'hFFFF_FFFF,  1'b1};
    vt[10] = '{0, 32'd5,          32'd3,          OP_SLT,   1'b0, 32'd0,          1'b1};
    vt[11] = '{1, 32'd0,          32'd0,          OP_SLTU,  1'b1, 32'd0,          1'b0};

    bus.i_req0_valid = 1'b0; bus.i_req1_valid = 1'b0;
    bus.i_req0_a = '0; bus.i_req0_b = '0; bus.i_req0_ctrl = '0; bus.i_req0_zcond = 1'b0;
    bus.i_req1_a = '0; bus.i_req1_b = '0; bus.i_req1_ctrl = '0; bus.i_req1_zcond = 1'b0;
    bus.i_rsp0_ready = 1'b1; bus.i_rsp1_ready = 1'b1;
    last_res[0] = '0; last_res[1] = '0;

    // Reset state, with a request held during reset that must not see ready.
    rst = 1'b1;
    drive_req(0, 0);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ready0", bus.o_req0_ready, 0);
    check("rst_rsp0_valid", bus.o_rsp0_valid, 0);
    check("rst_rsp1_valid", bus.o_rsp1_valid, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_ctrl", alu_ctrl, 0);
    check("rst_rsp0_result", bus.o_rsp0_result, 0);
    idle_req(0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_no_ready", bus.o_req0_ready | bus.o_req1_ready, 0);
      check("idle_not_busy", busy, 0);
    end
    @(posedge clk); #1;

    // Contention after reset, then the next contention, then continuous round-robin.
    q0 = '{1}; q1 = '{2}; exp_order = '{0, 1};
    run_ops(40);
    q0 = '{3}; q1 = '{4}; exp_order = '{0, 1};
    run_ops(40);
    q0 = '{5, 7, 10}; q1 = '{6, 8, 9}; exp_order = '{0, 1, 0, 1, 0, 1};
    run_ops(80);
    q0 = '{0}; q1 = '{}; exp_order = '{0};
    run_ops(20);
    q0 = '{}; q1 = '{11}; exp_order = '{1};
    run_ops(20);

    // Backpressure on requester 1 with requester 0 waiting.
    bus.i_rsp1_ready = 1'b0;
    drive_req(1, 6);
    wait_ready(1, ok);
    @(posedge clk); #1;
    idle_req(1);
    drive_req(0, 0);
    for (int i = 0; i < 5 && !bus.o_rsp1_valid; i++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_valid", bus.o_rsp1_valid, 1);
      check("bp_result", bus.o_rsp1_result, 32'h0000_F000);
      check("bp_zero", bus.o_rsp1_zero, 0);
      check("bp_no_ready", bus.o_req0_ready | bus.o_req1_ready, 0);
      check("bp_rsp0_held", bus.o_rsp0_result, last_res[0]);
    end
    @(negedge clk);
    check("bp_valid_last", bus.o_rsp1_valid, 1);
    bus.i_rsp1_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    $display("bp accept r1 result=%08h", 32'h0000_F000);
    check("bp_idle_busy", busy, 0);
    check("bp_valid_drop", bus.o_rsp1_valid, 0);
    check("bp_pending_granted", bus.o_req0_ready, 1);
    idle_req(0);
    last_res[1] = 32'h0000_F000;
    @(posedge clk); #1;

    // Reset while an SLTU operation from requester 1 sits in EXEC.
    drive_req(1, 4);
    wait_ready(1, ok);
    @(posedge clk); #1;
    idle_req(1);
    check("exec_busy", busy, 1);
    check("exec_alu_ctrl", alu_ctrl, OP_SLTU);
    check("exec_alu_b", alu_b, 32'hFFFF_FFFF);
    #2 rst = 1'b1;
    #1;
    $display("reset asserted during EXEC");
    check("rexec_busy", busy, 0);
    check("rexec_ready", bus.o_req0_ready | bus.o_req1_ready, 0);
    check("rexec_rsp_valid", bus.o_rsp0_valid | bus.o_rsp1_valid, 0);
    check("rexec_alu_a", alu_a, 0);
    check("rexec_alu_b", alu_b, 0);
    check("rexec_alu_ctrl", alu_ctrl, 0);
    check("rexec_rsp1_result", bus.o_rsp1_result, 0);
    check("rexec_rsp0_result", bus.o_rsp0_result, 0);
    @(negedge clk);
    rst = 1'b0;
    last_res[0] = '0; last_res[1] = '0;
    repeat (6) begin
      @(negedge clk);
      check("rexec_no_rsp1", bus.o_rsp1_valid, 0);
      check("rexec_idle", busy, 0);
    end
    @(posedge clk); #1;

    // last-grant is back to its reset value, so requester 0 wins again.
    q0 = '{0}; q1 = '{2}; exp_order = '{0, 1};
    run_ops(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/riscv_alu_arbiter.md
RISCV_ALU_ARBITER -- requirements
Module: riscv_alu_arbiter

Interface
REQ-001 SHALL use parameter XLEN, default `XLEN (32, from riscv_configs.v), as the operand and result width.
REQ-002 SHALL provide ports (name direction width meaning), clock and reset first:
 i_clk  in  1  clock, rising-edge
 i_rst  in  1  reset, asynchronous, active-high
 i_req0_valid / i_req1_valid  in  1  requester 0/1 operation request
 o_req0_ready / o_req1_ready  out  1  request accepted this cycle
 i_req0_a / i_req1_a  in  XLEN  operand A
 i_req0_b / i_req1_b  in  XLEN  operand B
 i_req0_ctrl / i_req1_ctrl  in  4  ALU_CTRL_* opcode
 i_req0_zcond / i_req1_zcond  in  1  zero condition
 o_rsp0_valid / o_rsp1_valid  out  1  response available
 i_rsp0_ready / i_rsp1_ready  in  1  response consumed
 o_rsp0_result / o_rsp1_result  out  XLEN  ALU result
 o_rsp0_zero / o_rsp1_zero  out  1  ALU zero flag
 o_alu_a, o_alu_b  out  XLEN  to shared riscv_alu i_alu_a/i_alu_b
 o_alu_ctrl  out  4  to i_alu_ctrl
 o_alu_zcond  out  1  to i_zero_condition
 i_alu_result  in  XLEN  from o_alu_result
 i_alu_zero  in  1  from o_alu_zero
 o_busy  out  1  high in any state other than IDLE
REQ-003 SHALL use the single clock i_clk and asynchronous active-high reset i_rst for all state.

Function
REQ-004 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-005 IDLE: with no requester valid, SHALL remain in IDLE and keep all ready outputs low.
REQ-006 IDLE: with exactly one requester valid, SHALL grant that requester.
REQ-007 IDLE: with both requesters valid, SHALL grant the requester not granted most recently (round-robin).
REQ-008 Grant SHALL assert the granted o_reqN_ready combinationally in the same IDLE cycle, with the other ready low.
REQ-009 On the grant edge, SHALL capture a, b, ctrl, zcond and the grant index into internal registers, then move to EXEC.
REQ-010 o_alu_a/b/ctrl/zcond SHALL be driven only from the operand registers, never from request inputs directly.
REQ-011 EXEC: SHALL capture i_alu_result and i_alu_zero into the response register of the granted index, then move to RESP.
REQ-012 RESP: SHALL hold o_rspN_valid high for the granted index, with result and zero stable, until i_rspN_ready is high.
REQ-013 On the RESP cycle with i_rspN_ready high, SHALL deassert valid on the next edge, return to IDLE, and update last-grant to N.
REQ-014 Request-accept to response-valid latency SHALL be exactly 2 cycles; minimum issue interval SHALL be 3 cycles.
REQ-015 o_reqN_ready SHALL be low in EXEC and RESP regardless of valid inputs; pending requests wait without loss.
REQ-016 At most one o_rspN_valid SHALL be high at any time; the non-granted response outputs SHALL keep their last values.
REQ-017 Opcodes SHALL pass unmodified; an undefined ctrl is forwarded and its result returned as produced by the ALU.
REQ-018 Widths SHALL be XLEN throughout, with no sign or zero extension performed.

Reset
REQ-019 i_rst SHALL force, asynchronously: state IDLE; operand, result and zero registers 0; all valid and ready outputs 0; o_busy 0; last-grant = 1, so requester 0 wins the first contention.
REQ-020 Reset asserted mid-operation (EXEC or RESP) SHALL discard the operation; no response for it SHALL appear after release.

Verification
REQ-021 Single request: r0 ADD a=5 b=7 zcond=0 accepted at cycle N -> o_rsp0_valid at N+2, result 12, zero 0.
REQ-022 Contention after reset: both valid (r0 SUB 9-9, r1 XOR 0xF^0xF0) -> r0 served first (result 0, zero 1 with zcond=0), then r1 (0xFF); the next contention grants r0.
REQ-023 Backpressure: i_rsp1_ready held low 5 cycles -> o_rsp1_valid and result stable for all 5 cycles, no new ready; accept -> IDLE the next cycle.
REQ-024 Round-robin: both requesters valid continuously for 6 operations -> grant sequence r0,r1,r0,r1,r0,r1, each response matching its operands.
REQ-025 Reset in EXEC: assert i_rst while r1 SLTU op is in EXEC -> all outputs 0 immediately; after release no o_rsp1_valid appears without a new request.
REQ-026 zcond=1 with SLT a=-1 b=0 -> result 1, zero 1 (nonzero under inverted condition).
